bmem_burst_arbiter: RTL and testbench

//  Round-robin arbiter that shares one burst memory port (bmem) among NUM_REQ cache DFP ports.

---
 rtl/bmem_burst_arbiter.sv | 100 ++++++++++
 tb/tb_bmem_burst_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bmem_burst_arbiter.sv
// bmem_burst_arbiter: round-robin arbiter sharing one burst memory port among NUM_REQ line ports.
// Define ARB_RADDR_CHECK_EN to discard read beats whose bmem_raddr line differs from the request.
module bmem_burst_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ*32-1:0]  i_dfp_addr,
   input  logic [NUM_REQ-1:0]     i_dfp_read,
   input  logic [NUM_REQ-1:0]     i_dfp_write,
   input  logic [NUM_REQ*256-1:0] i_dfp_wdata,
   output logic [255:0]           o_dfp_rdata,
   output logic [NUM_REQ-1:0]     o_dfp_resp,
   output logic [31:0]            o_bmem_addr,
   output logic                   o_bmem_read,
   output logic                   o_bmem_write,
   output logic [63:0]            o_bmem_wdata,
   input  logic                   i_bmem_ready,
   input  logic [31:0]            i_bmem_raddr,
   input  logic [63:0]            i_bmem_rdata,
   input  logic                   i_bmem_rvalid
);
   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_BURST, RESP} state_t;
   state_t             r_state;
   logic [PTR_W-1:0]   r_ptr, r_grant, w_idx, w_j;
   logic               r_wr, r_wr_act, w_any, w_acc, w_unused;
   logic [1:0]         r_cnt;
   logic [31:0]        r_addr, w_sel_addr;
   logic [255:0]       r_wdata, r_line;
   logic [NUM_REQ-1:0] w_req;
   assign w_req = i_dfp_read | i_dfp_write;
   // Descending scan so the requester closest to r_ptr is written last and wins.
   always_comb begin
      w_idx = r_ptr;
      w_any = 1'b0;
      w_j   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_j = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
         if (w_req[w_j]) begin
            w_idx = w_j;
            w_any = 1'b1;
         end
      end
   end
   assign w_sel_addr = i_dfp_addr[32*w_idx +: 32];
`ifdef ARB_RADDR_CHECK_EN
   assign w_acc = (r_state == RD_WAIT) && i_bmem_rvalid && (i_bmem_raddr[31:5] == r_addr[31:5]);
`else
   assign w_acc = (r_state == RD_WAIT) && i_bmem_rvalid;
`endif
   assign w_unused     = ^{i_bmem_raddr, w_sel_addr[4:0]};
   assign o_bmem_read  = (r_state == RD_ISSUE) && i_bmem_ready;
   assign o_bmem_write = (r_state == WR_BURST) && (r_wr_act || i_bmem_ready);
   assign o_bmem_addr  = (o_bmem_read || o_bmem_write) ? r_addr : '0;
   assign o_bmem_wdata = o_bmem_write ? r_wdata[64*r_cnt +: 64] : '0;
   assign o_dfp_resp   = (r_state == RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant) : '0;
   assign o_dfp_rdata  = (r_state == RESP && !r_wr) ? r_line : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_ptr    <= '0;
         r_grant  <= '0;
         r_wr     <= 1'b0;
         r_wr_act <= 1'b0;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_line   <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_any) begin
               r_grant <= w_idx;
               r_addr  <= {w_sel_addr[31:5], 5'b0};
               r_wr    <= i_dfp_write[w_idx];
               r_wdata <= i_dfp_wdata[256*w_idx +: 256];
               r_cnt   <= '0;
               r_state <= i_dfp_write[w_idx] ? WR_BURST : RD_ISSUE;
            end
            RD_ISSUE: if (i_bmem_ready) r_state <= RD_WAIT;
            RD_WAIT: if (w_acc) begin
               r_line[64*r_cnt +: 64] <= i_bmem_rdata;
               r_cnt <= r_cnt + 2'd1;
               if (r_cnt == 2'd3) r_state <= RESP;
            end
            // Once the first beat is accepted the burst runs without further ready checks.
            WR_BURST: if (o_bmem_write) begin
               r_wr_act <= (r_cnt != 2'd3);
               r_cnt    <= r_cnt + 2'd1;
               if (r_cnt == 2'd3) r_state <= RESP;
            end
            RESP: begin
               r_ptr   <= (int'(r_grant) == NUM_REQ - 1) ? '0 : r_grant + 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bmem_burst_arbiter.sv
// tb_bmem_burst_arbiter: directed checks of grant order, read assembly, write bursts, stalls and reset.
module tb_bmem_burst_arbiter;
   logic          clk;
   logic          rst;
   logic [127:0]  i_dfp_addr;
   logic [3:0]    i_dfp_read, i_dfp_write;
   logic [1023:0] i_dfp_wdata;
   logic [255:0]  o_dfp_rdata;
   logic [3:0]    o_dfp_resp;
   logic [31:0]   o_bmem_addr;
   logic          o_bmem_read, o_bmem_write;
   logic [63:0]   o_bmem_wdata;
   logic          i_bmem_ready;
   logic [31:0]   i_bmem_raddr;
   logic [63:0]   i_bmem_rdata;
   logic          i_bmem_rvalid;
   int            n_pass = 0;
   int            n_total = 0;

   bmem_burst_arbiter dut (
      .clk(clk), .rst(rst),
      .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read), .i_dfp_write(i_dfp_write),
      .i_dfp_wdata(i_dfp_wdata), .o_dfp_rdata(o_dfp_rdata), .o_dfp_resp(o_dfp_resp),
      .o_bmem_addr(o_bmem_addr), .o_bmem_read(o_bmem_read), .o_bmem_write(o_bmem_write),
      .o_bmem_wdata(o_bmem_wdata), .i_bmem_ready(i_bmem_ready), .i_bmem_raddr(i_bmem_raddr),
      .i_bmem_rdata(i_bmem_rdata), .i_bmem_rvalid(i_bmem_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [63:0]  bt[5];
   logic [255:0] wline;
   int           w;

   initial begin
      rst = 1'b1; i_dfp_addr = '0; i_dfp_read = '0; i_dfp_write = '0; i_dfp_wdata = '0;
      i_bmem_ready = 1'b1; i_bmem_raddr = '0; i_bmem_rdata = '0; i_bmem_rvalid = 1'b0;
      repeat (2) cyc();
      chk("rst_resp", o_dfp_resp, 4'b0);
      chk("rst_read", o_bmem_read, 1'b0);
      chk("rst_write", o_bmem_write, 1'b0);
      chk("rst_addr", o_bmem_addr, 32'h0);
      chk("rst_rdata", o_dfp_rdata, 256'h0);
      rst = 1'b0;

      // T1 single read by requester 1
      bt[0] = 64'hAAAA_0000_0000_000A; bt[1] = 64'hBBBB_0000_0000_000B;
      bt[2] = 64'hCCCC_0000_0000_000C; bt[3] = 64'hDDDD_0000_0000_000D;
      i_dfp_addr[63:32] = 32'h0000_1040; i_dfp_read[1] = 1'b1;
      cyc();
      chk("t1_read", o_bmem_read, 1'b1);
      chk("t1_addr", o_bmem_addr, 32'h0000_1040);
      cyc();
      chk("t1_read_once", o_bmem_read, 1'b0);
      for (int b = 0; b < 4; b++) begin
         i_bmem_rvalid = 1'b1; i_bmem_rdata = bt[b];
         cyc();
      end
      i_bmem_rvalid = 1'b0;
      chk("t1_resp", o_dfp_resp, 4'b0010);
      chk("t1_rdata", o_dfp_rdata, {bt[3], bt[2], bt[1], bt[0]});
      i_dfp_read = '0;
      cyc();
      chk("t1_resp_pulse", o_dfp_resp, 4'b0);

      // T2 single write by requester 3
      wline = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_4433_2211};
      i_dfp_wdata[1023:768] = wline; i_dfp_addr[127:96] = 32'h0000_2000; i_dfp_write[3] = 1'b1;
      cyc();
      for (int k = 0; k < 4; k++) begin
         chk("t2_write", o_bmem_write, 1'b1);
         chk("t2_wdata", o_bmem_wdata, wline[64*k +: 64]);
         chk("t2_addr", o_bmem_addr, 32'h0000_2000);
         chk("t2_no_read", o_bmem_read, 1'b0);
         cyc();
      end
      chk("t2_write_end", o_bmem_write, 1'b0);
      chk("t2_resp", o_dfp_resp, 4'b1000);
      chk("t2_rdata_zero", o_dfp_rdata, 256'h0);
      i_dfp_write = '0;
      cyc();
      chk("t2_resp_pulse", o_dfp_resp, 4'b0);

      // T3 fairness: all four reading continuously from reset
      rst = 1'b1;
      i_dfp_addr = {32'h0000_4060, 32'h0000_4040, 32'h0000_4020, 32'h0000_4000};
      i_dfp_read = 4'b1111; i_bmem_rvalid = 1'b1;
      cyc();
      rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         i_bmem_rdata = 64'hF00 + 64'(n);
         w = 0;
         while (o_dfp_resp === 4'b0 && w < 20) begin
            cyc();
            w++;
         end
         chk("t3_grant", o_dfp_resp, 4'b0001 << (n % 4));
         chk("t3_rdata", o_dfp_rdata, {4{64'hF00 + 64'(n)}});
         cyc();
      end
      i_dfp_read = '0; i_bmem_rvalid = 1'b0;

      // T4 ready stall in RD_ISSUE; low address bits ignored
      i_bmem_ready = 1'b0; i_dfp_addr[31:0] = 32'h0000_501F; i_dfp_read[0] = 1'b1;
      cyc();
      for (int s = 0; s < 5; s++) begin
         chk("t4_stall_read", o_bmem_read, 1'b0);
         cyc();
      end
      i_bmem_ready = 1'b1;
      #1;
      chk("t4_accept", o_bmem_read, 1'b1);
      chk("t4_addr", o_bmem_addr, 32'h0000_5000);
      cyc();
      chk("t4_single", o_bmem_read, 1'b0);
      for (int b = 0; b < 4; b++) begin
         i_bmem_rvalid = 1'b1; i_bmem_rdata = bt[3-b];
         cyc();
      end
      i_bmem_rvalid = 1'b0;
      chk("t4_resp", o_dfp_resp, 4'b0001);
      chk("t4_rdata", o_dfp_rdata, {bt[0], bt[1], bt[2], bt[3]});
      i_dfp_read = '0;
      cyc();

      // T5 reset after write beat 1
      i_dfp_wdata[767:512] = {64'h5555_0003, 64'h5555_0002, 64'h5555_0001, 64'h5555_0000};
      i_dfp_addr[95:64] = 32'h0000_3000; i_dfp_write[2] = 1'b1;
      cyc();
      chk("t5_beat0", o_bmem_wdata, 64'h5555_0000);
      cyc();
      chk("t5_beat1", o_bmem_wdata, 64'h5555_0001);
      rst = 1'b1; i_dfp_write = '0;
      cyc();
      chk("t5_write_off", o_bmem_write, 1'b0);
      chk("t5_addr_zero", o_bmem_addr, 32'h0);
      chk("t5_wdata_zero", o_bmem_wdata, 64'h0);
      chk("t5_resp_zero", o_dfp_resp, 4'b0);
      rst = 1'b0;
      for (int b = 0; b < 4; b++) begin
         i_bmem_rvalid = 1'b1; i_bmem_rdata = 64'hDEAD_0000 + 64'(b); i_bmem_raddr = 32'h0000_3000;
         cyc();
         chk("t5_stray_resp", o_dfp_resp, 4'b0);
      end
      i_bmem_rvalid = 1'b0;
      chk("t5_stray_rdata", o_dfp_rdata, 256'h0);

      // T6 stray beat from another line during a read of 0x1000
      bt[0] = 64'h5757_0000_0000_0BAD;
      bt[1] = 64'h6060_0000_0000_0001; bt[2] = 64'h6060_0000_0000_0002;
      bt[3] = 64'h6060_0000_0000_0003; bt[4] = 64'h6060_0000_0000_0004;
      i_dfp_addr[63:32] = 32'h0000_1000; i_dfp_read[1] = 1'b1;
      cyc();
      chk("t6_addr", o_bmem_addr, 32'h0000_1000);
      cyc();
      for (int b = 0; b < 5; b++) begin
         if (o_dfp_resp === 4'b0) begin
            i_bmem_rvalid = 1'b1; i_bmem_rdata = bt[b];
            i_bmem_raddr = (b == 0) ? 32'h0000_3000 : 32'h0000_1000;
            cyc();
         end
      end
      i_bmem_rvalid = 1'b0;
      chk("t6_resp", o_dfp_resp, 4'b0010);
`ifdef ARB_RADDR_CHECK_EN
      chk("t6_rdata", o_dfp_rdata, {bt[4], bt[3], bt[2], bt[1]});
`else
      chk("t6_rdata", o_dfp_rdata, {bt[3], bt[2], bt[1], bt[0]});
`endif
      i_dfp_read = '0;
      cyc();
      chk("t6_idle", o_dfp_resp, 4'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
